// File: rtl/debounce_pulse_if.sv
// Button-conditioning bundle between the raw switch and the debounced outputs
// that feed the downstream flip-flop chains.
interface debounce_pulse_if;
  logic btn;
  logic level;
  logic pulse;
  logic busy;

  modport master (output btn, input level, input pulse, input busy);
  modport slave  (input btn, output level, output pulse, output busy);
endinterface

// File: rtl/debounce_pulse.sv
// Synchronises and debounces a bouncing button into a clean level plus one press pulse.
// Optional auto-repeat pulses while held are enabled by defining DEBOUNCE_REPEAT_EN.
module debounce_pulse #(
  parameter int STABLE_CYCLES = 8,
  parameter bit ACTIVE_LOW    = 1'b1
`ifdef DEBOUNCE_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 10
`endif
) (
  input logic             clk,
  input logic             clr,
  debounce_pulse_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  // One-hot encoding keeps the busy decode glitch-free
  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    ARMING    = 4'b0010,
    PRESSED   = 4'b0100,
    RELEASING = 4'b1000
  } stateType;

  stateType      state, stateNext;
  logic          sync1, sync2;
  logic [CW-1:0] stableCnt, stableCntNext;
  logic          levelReg, levelNext;
  logic          pulseReg, pulseNext, pulseAccept;
  logic          pressedRaw;

  assign pressedRaw = bus.btn ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      state     <= IDLE;
      stableCnt <= '0;
      levelReg  <= 1'b0;
      pulseReg  <= 1'b0;
    end else begin
      sync1     <= pressedRaw;
      sync2     <= sync1;
      state     <= stateNext;
      stableCnt <= stableCntNext;
      levelReg  <= levelNext;
      pulseReg  <= pulseNext;
    end
  end

  // Any state not listed falls back to IDLE with every output low
  always_comb begin
    stateNext     = IDLE;
    stableCntNext = '0;
    levelNext     = 1'b0;
    pulseAccept   = 1'b0;
    case (state)
      IDLE: begin
        if (sync2) stateNext = ARMING;
      end
      ARMING: begin
        if (!sync2) begin
          stateNext = IDLE;
        end else if (stableCnt == LAST) begin
          stateNext   = PRESSED;
          levelNext   = 1'b1;
          pulseAccept = 1'b1;
        end else begin
          stateNext     = ARMING;
          stableCntNext = stableCnt + 1'b1;
        end
      end
      PRESSED: begin
        levelNext = 1'b1;
        stateNext = sync2 ? PRESSED : RELEASING;
      end
      RELEASING: begin
        if (sync2) begin
          stateNext = PRESSED;
          levelNext = 1'b1;
        end else if (stableCnt == LAST) begin
          stateNext = IDLE;
        end else begin
          stateNext     = RELEASING;
          levelNext     = 1'b1;
          stableCntNext = stableCnt + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_WRAP  = RW'(REPEAT_DELAY + REPEAT_PERIOD);

  logic [RW-1:0] repCnt, repCntNext;
  logic          repFire;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) repCnt <= '0;
    else      repCnt <= repCntNext;
  end

  // Counts only while held; folding back to REP_FIRST yields the periodic pulses
  always_comb begin
    repCntNext = '0;
    repFire    = 1'b0;
    if (state == PRESSED && sync2) begin
      repCntNext = repCnt + 1'b1;
      if (repCntNext == REP_FIRST) begin
        repFire = 1'b1;
      end else if (repCntNext == REP_WRAP) begin
        repFire    = 1'b1;
        repCntNext = REP_FIRST;
      end
    end else if (state == PRESSED || (state == RELEASING && stateNext != IDLE)) begin
      repCntNext = repCnt;
    end
  end

  assign pulseNext = pulseAccept | repFire;
`else
  assign pulseNext = pulseAccept;
`endif

  assign bus.level = levelReg;
  assign bus.pulse = pulseReg;
  assign bus.busy  = (state == ARMING) || (state == RELEASING);

endmodule

// File: tb/tb_debounce_pulse.sv
// Scoreboard bench for debounce_pulse: directed button sequences push expected
// pulse cycles; a negedge monitor pops and compares every pulse the DUT emits.
module tb_debounce_pulse;

  logic clk = 1'b0;
  logic clr;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   expQ[$];
  int   expCyc;

  debounce_pulse_if bus ();

  debounce_pulse #(
    .STABLE_CYCLES(8),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every observed pulse must match the oldest expected pulse cycle
  always @(negedge clk) begin
    if (bus.pulse === 1'b1) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL pulse_unexpected: pulse seen at cycle %0d, required no pulse", cyc);
      end else begin
        expCyc = expQ.pop_front();
        if (cyc != expCyc) begin
          bad++;
          $display("[TB] FAIL pulse_timing: pulse at cycle %0d, required cycle %0d", cyc, expCyc);
        end
      end
    end
  end

  task automatic applyStimulus(input bit pressed, input int edges);
    bus.btn = pressed ? 1'b0 : 1'b1;
    repeat (edges) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic expLevel,
                             input logic expBusy, input logic expPulse);
    total++;
    if (bus.level !== expLevel || bus.busy !== expBusy || bus.pulse !== expPulse) begin
      bad++;
      $display("[TB] FAIL %s: level=%b busy=%b pulse=%b, required level=%b busy=%b pulse=%b",
               name, bus.level, bus.busy, bus.pulse, expLevel, expBusy, expPulse);
    end
  endtask

  task automatic expectPulse(input int at);
    expQ.push_back(at);
  endtask

  initial begin
    int c;
    clr     = 1'b0;
    bus.btn = 1'b0;

    // Reset held with the button already pressed
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold", 1'b0, 1'b0, 1'b0);
    end
    clr = 1'b1;
    c = cyc;

    // Clean press: accepted 11 edges after the first sample, held 30 cycles
    expectPulse(c + 11);
`ifdef DEBOUNCE_REPEAT_EN
    expectPulse(c + 31);
`endif
    applyStimulus(1'b1, 2);
    checkOutput("pre_arm", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1);
    checkOutput("arming_start", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 7);
    checkOutput("arming_end", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1);
    checkOutput("accept", 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1);
    checkOutput("single_pulse", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 18);
    checkOutput("held", 1'b1, 1'b0, 1'b0);

    // Full release: level falls 11 edges after the release sample
    applyStimulus(1'b0, 10);
    checkOutput("release_qualify", 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1);
    checkOutput("released", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4);

    // Bounce: 5 pressed, 2 released, 3 pressed, then released
    applyStimulus(1'b1, 5);
    checkOutput("bounce_arming", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 8);
    checkOutput("bounce_rejected", 1'b0, 1'b0, 1'b0);

    // Release glitch of 4 cycles during a held press
    c = cyc;
    expectPulse(c + 11);
    applyStimulus(1'b1, 11);
    checkOutput("glitch_accept", 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 4);
    checkOutput("glitch_releasing", 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8);
    checkOutput("glitch_recovered", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 10);
    checkOutput("glitch_full_release_qualify", 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1);
    checkOutput("glitch_full_release", 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4);

    // Async clear while ARMING at count 5
    applyStimulus(1'b1, 8);
    checkOutput("arming_count5", 1'b0, 1'b1, 1'b0);
    #2 clr = 1'b0;
    #1 checkOutput("async_clear_arming", 1'b0, 1'b0, 1'b0);
    #1 clr = 1'b1;
    c = cyc;
    expectPulse(c + 11);
    applyStimulus(1'b1, 10);
    checkOutput("requalify_edge10", 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1);
    checkOutput("requalify_accept", 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 3);

    // Async clear while LEVEL is high
    #2 clr = 1'b0;
    #1 checkOutput("async_clear_pressed", 1'b0, 1'b0, 1'b0);
    #1 clr = 1'b1;
    c = cyc;
    expectPulse(c + 11);
    applyStimulus(1'b1, 11);
    checkOutput("post_clear_accept", 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 14);
    checkOutput("post_clear_release", 1'b0, 1'b0, 1'b0);

    // Long hold: single pulse by default, auto-repeat when enabled
    c = cyc;
    expectPulse(c + 11);
`ifdef DEBOUNCE_REPEAT_EN
    expectPulse(c + 31);
    expectPulse(c + 41);
    expectPulse(c + 51);
    expectPulse(c + 61);
`endif
    applyStimulus(1'b1, 65);
    checkOutput("long_hold", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 20);
    checkOutput("long_release", 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 3);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL pulses_missing: %0d expected pulses outstanding, required 0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
